// File: rtl/mdu_pkg.sv
// Shared types, defaults and small helpers for the multiply/divide unit.
package mdu_pkg;

  localparam int DEF_MUL_LAT   = 2;
  localparam int DEF_DIV_ITERS = 32;

  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MUL   = 4'd4,
    MADD  = 4'd5,
    MADDU = 4'd6,
    MSUB  = 4'd7,
    MSUBU = 4'd8
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DIV_BUSY,
    DONE
  } mdu_state_t;

  function automatic logic isDivOp(input mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Ops whose operands are interpreted as two's complement.
  function automatic logic isSignedOp(input mdu_op_t op);
    return (op == MULT) || (op == DIV) || (op == MUL) || (op == MADD) || (op == MSUB);
  endfunction

  // Extend a 32-bit operand to 64 bits so that the truncated 64x64 product
  // equals the exact signed or unsigned 32x32 product.
  function automatic logic [63:0] extOperand(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle.
// A zero divisor naturally yields quotient=all ones, remainder=dividend.
module div_iter import mdu_pkg::*; #(
  parameter int ITERS = DEF_DIV_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CNT_W = $clog2(ITERS + 1);

  logic             busy;
  logic [CNT_W-1:0] iterCnt;
  logic [31:0]      divisorQ;
  logic [32:0]      partial;
  logic [33:0]      trial;

  // Shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    partial = {remainder, quotient[31]};
    trial   = {1'b0, partial} - {2'b00, divisorQ};
  end

  // Iteration register: the quotient register doubles as the dividend shifter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block samples the pre-edge values of the others.
    if (rst || abort) begin
      busy      <= 1'b0;
      iterCnt   <= '0;
      divisorQ  <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      iterCnt   <= CNT_W'(ITERS);
      divisorQ  <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      if (!trial[33]) begin
        remainder <= trial[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= partial[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
      iterCnt <= iterCnt - CNT_W'(1);
      if (iterCnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  // High during the cycle whose closing edge writes the final quotient bit,
  // so the controller can enter DONE exactly when the result lands.
  assign done = busy && (iterCnt == CNT_W'(1));

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide controller: sequences the multiplier pipeline and
// the iterative divider, stalls the pipe while busy and owns HI/LO.
module mdu_ctrl import mdu_pkg::*; #(
  parameter int MUL_LAT   = DEF_MUL_LAT,
  parameter int DIV_ITERS = DEF_DIV_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] mul_res_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int PIPE_DEPTH = MUL_LAT - 1;
  localparam int CNT_W      = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 2);

  mdu_state_t       state, nextState;
  mdu_op_t          opIn, opQ;
  logic [31:0]      aQ, bQ;
  logic             negQuo, negRem;
  logic [CNT_W-1:0] mulCnt;
  logic             accept, divStart, commit;

  logic [63:0]      mulProd, mulP;
  logic [63:0]      mulPipe [PIPE_DEPTH];

  logic [31:0]      divDividend, divDivisor, divQuo, divRem, quoFix, remFix;
  logic             divDone;

  logic [63:0]      hiLo, newHiLo;
  logic             writesHiLo;
  logic [31:0]      hiQ, loQ;

  assign opIn = mdu_op_t'(op_i);

  // The divider works on magnitudes; signs are restored after the divide.
  always_comb begin
    divDividend = (isSignedOp(opIn) && a_i[31]) ? (~a_i + 32'd1) : a_i;
    divDivisor  = (isSignedOp(opIn) && b_i[31]) ? (~b_i + 32'd1) : b_i;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and handshake outputs; flush overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    nextState = state;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    accept    = 1'b0;
    divStart  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (en_i) begin
          stall_o = 1'b1;
          accept  = 1'b1;
          if (isDivOp(opIn)) begin
            divStart  = 1'b1;
            nextState = DIV_BUSY;
          end else begin
            nextState = MUL_BUSY;
          end
        end
      end
      MUL_BUSY: begin
        stall_o = 1'b1;
        if (mulCnt == '0) nextState = DONE;
      end
      DIV_BUSY: begin
        stall_o = 1'b1;
        if (divDone) nextState = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (!hold_i) begin
          commit    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (flush_i) begin
      nextState = IDLE;
      stall_o   = 1'b0;
      done_o    = 1'b0;
      accept    = 1'b0;
      divStart  = 1'b0;
      commit    = 1'b0;
    end
  end

  // Capture the operation and operands, plus the sign fixups a divide needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      opQ    <= MULT;
      aQ     <= '0;
      bQ     <= '0;
      negQuo <= 1'b0;
      negRem <= 1'b0;
    end else if (accept) begin
      opQ    <= opIn;
      aQ     <= a_i;
      bQ     <= b_i;
      negQuo <= isSignedOp(opIn) && (a_i[31] ^ b_i[31]);
      negRem <= isSignedOp(opIn) && a_i[31];
    end
  end

  // Multiply latency counter: MUL_BUSY lasts MUL_LAT-1 cycles.
  always_ff @(posedge clk) begin
    if (rst)                                      mulCnt <= '0;
    else if (accept)                              mulCnt <= MUL_CNT_INIT;
    else if (state == MUL_BUSY && mulCnt != '0)   mulCnt <= mulCnt - CNT_W'(1);
  end

  assign mulProd = extOperand(aQ, isSignedOp(opQ)) * extOperand(bQ, isSignedOp(opQ));

  // Product pipeline; the latched operands stay put, so the tail is stable in DONE.
  always_ff @(posedge clk) begin
    // NOTE: the pipeline is reset because its tail drives mul_res_o, which
    // must read zero out of reset.
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) mulPipe[i] <= '0;
    end else begin
      mulPipe[0] <= mulProd;
      for (int i = 1; i < PIPE_DEPTH; i++) mulPipe[i] <= mulPipe[i-1];
    end
  end

  assign mulP      = mulPipe[PIPE_DEPTH-1];
  assign mul_res_o = mulP[31:0];

  div_iter #(
    .ITERS(DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (divStart),
    .abort    (flush_i),
    .dividend (divDividend),
    .divisor  (divDivisor),
    .done     (divDone),
    .quotient (divQuo),
    .remainder(divRem)
  );

  assign quoFix = negQuo ? (~divQuo + 32'd1) : divQuo;
  assign remFix = negRem ? (~divRem + 32'd1) : divRem;

  // Value HI/LO take on commit; accumulating ops use HI/LO as they are now.
  always_comb begin
    hiLo       = {hiQ, loQ};
    newHiLo    = hiLo;
    writesHiLo = 1'b1;
    case (opQ)
      MULT, MULTU: newHiLo = mulP;
      MADD, MADDU: newHiLo = hiLo + mulP;
      MSUB, MSUBU: newHiLo = hiLo - mulP;
      DIV, DIVU:   newHiLo = {remFix, quoFix};
      default:     writesHiLo = 1'b0;
    endcase
  end

  // Architectural HI/LO: an MDU commit wins over a same-edge MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      hiQ <= '0;
      loQ <= '0;
    end else if (commit && writesHiLo) begin
      hiQ <= newHiLo[63:32];
      loQ <= newHiLo[31:0];
    end else begin
      if (mthi_i) hiQ <= wdata_i;
      if (mtlo_i) loQ <= wdata_i;
    end
  end

  assign hi_o = hiQ;
  assign lo_o = loQ;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with a cycle-level reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MUL_LAT   = 2;
  localparam int DIV_ITERS = 32;

  logic        clk = 1'b0;
  logic        rst, en_i, flush_i, hold_i, mthi_i, mtlo_i;
  logic [3:0]  op_i;
  logic [31:0] a_i, b_i, wdata_i;
  logic        stall_o, done_o;
  logic [31:0] mul_res_o, hi_o, lo_o;

  int nChecks = 0;
  int nErrors = 0;

  mdu_ctrl #(
    .MUL_LAT  (MUL_LAT),
    .DIV_ITERS(DIV_ITERS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .hold_i   (hold_i),
    .mthi_i   (mthi_i),
    .mtlo_i   (mtlo_i),
    .wdata_i  (wdata_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .mul_res_o(mul_res_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] modelProd(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (op inside {MULT, MADD, MSUB, MUL}) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] modelDiv(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, (op == DIV && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF};
    if (op == DIV) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [63:0] modelHiLo(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] cur);
    case (op)
      MULT, MULTU: return modelProd(op, a, b);
      MADD, MADDU: return cur + modelProd(op, a, b);
      MSUB, MSUBU: return cur - modelProd(op, a, b);
      DIV, DIVU:   return modelDiv(op, a, b);
      default:     return cur;
    endcase
  endfunction

  bit          modelOn = 0;
  bit          mActive = 0;
  int          mAge = 0;
  int          mLat = 0;
  mdu_op_t     mOp = MULT;
  logic [31:0] mA = '0, mB = '0, mHi = '0, mLo = '0;
  bit          mCommit;
  logic [63:0] mNew, mP;
  bit          expStall, expDone;

  // Model update: an op is "age" cycles past its accept cycle; it stalls while
  // age < latency, then reports done until it commits with hold_i low.
  always @(posedge clk) begin
    if (rst) begin
      mActive = 0;
      mHi     = '0;
      mLo     = '0;
    end else begin
      mCommit = 0;
      if (flush_i) begin
        mActive = 0;
      end else if (!mActive) begin
        if (en_i) begin
          mActive = 1;
          mAge    = 1;
          mOp     = mdu_op_t'(op_i);
          mA      = a_i;
          mB      = b_i;
          mLat    = (mOp inside {DIV, DIVU}) ? DIV_ITERS + 1 : MUL_LAT;
        end
      end else if (mAge < mLat) begin
        mAge++;
      end else if (!hold_i) begin
        mCommit = 1;
        mActive = 0;
      end
      if (mCommit && mOp != MUL) begin
        mNew = modelHiLo(mOp, mA, mB, {mHi, mLo});
        mHi  = mNew[63:32];
        mLo  = mNew[31:0];
      end else begin
        if (mthi_i) mHi = wdata_i;
        if (mtlo_i) mLo = wdata_i;
      end
    end
  end

  // Compare process: every cycle after reset, away from the active edge.
  always @(negedge clk) begin
    if (modelOn && !rst) begin
      expDone  = !flush_i && mActive && (mAge >= mLat);
      expStall = !flush_i && (mActive ? (mAge < mLat) : en_i);
      check("cycle stall_o", stall_o, expStall);
      check("cycle done_o", done_o, expDone);
      check("cycle hi_o", hi_o, mHi);
      check("cycle lo_o", lo_o, mLo);
      if (expDone && mOp == MUL) begin
        mP = modelProd(mOp, mA, mB);
        check("cycle mul_res_o", mul_res_o, mP[31:0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Starts at posedge+1 (cycle 0); returns at the negedge of the first done cycle.
  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output int doneAt, output int stallCnt);
    doneAt   = -1;
    stallCnt = 0;
    en_i = 1'b1;
    op_i = op;
    a_i  = a;
    b_i  = b;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_o) begin
        doneAt = c;
        break;
      end
      if (stall_o) stallCnt++;
      @(posedge clk);
      #1;
      en_i = 1'b0;
    end
    en_i = 1'b0;
    if (doneAt < 0) check("done_o within budget", done_o, 1'b1);
  endtask

  task automatic finishOp();
    @(posedge clk);
    #1;
  endtask

  task automatic runOp(input string name, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input int expDoneAt, input logic [31:0] expHi, input logic [31:0] expLo);
    int doneAt, stallCnt;
    issue(op, a, b, doneAt, stallCnt);
    check({name, " done cycle"}, doneAt, expDoneAt);
    check({name, " stall cycles"}, stallCnt, expDoneAt);
    finishOp();
    check({name, " hi"}, hi_o, expHi);
    check({name, " lo"}, lo_o, expLo);
  endtask

  task automatic writeReg(input bit toHi, input logic [31:0] val);
    mthi_i  = toHi;
    mtlo_i  = !toHi;
    wdata_i = val;
    @(posedge clk);
    #1;
    mthi_i = 1'b0;
    mtlo_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int doneAt, stallCnt, doneCnt, sawDone;
    rst = 1'b1; en_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    flush_i = 1'b0; hold_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    modelOn = 1;

    @(negedge clk);
    check("reset stall_o", stall_o, 1'b0);
    check("reset done_o", done_o, 1'b0);
    check("reset hi_o", hi_o, 32'h0);
    check("reset lo_o", lo_o, 32'h0);
    check("reset mul_res_o", mul_res_o, 32'h0);
    @(posedge clk);
    #1;

    runOp("MULT -1*2",   MULT, 32'hFFFF_FFFF, 32'd2, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("DIVU 100/7",  DIVU, 32'd100, 32'd7,       33, 32'd2,         32'd14);
    runOp("DIVU 5/0",    DIVU, 32'd5, 32'd0,         33, 32'd5,         32'hFFFF_FFFF);
    runOp("DIV -7/2",    DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("DIV 7/-2",    DIV,  32'd7, 32'hFFFF_FFFE, 33, 32'd1,         32'hFFFF_FFFD);
    runOp("DIV -5/0",    DIV,  32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'd1);

    writeReg(1'b1, 32'h0);
    writeReg(1'b0, 32'hFFFF_FFFF);
    check("mthi value", hi_o, 32'h0);
    check("mtlo value", lo_o, 32'hFFFF_FFFF);
    runOp("MADDU 1*1",   MADDU, 32'd1, 32'd1,        2,  32'd1,         32'd0);
    runOp("MSUBU 1*1",   MSUBU, 32'd1, 32'd1,        2,  32'd0,         32'hFFFF_FFFF);

    issue(MUL, 32'd3, 32'd5, doneAt, stallCnt);
    check("MUL done cycle", doneAt, 2);
    check("MUL mul_res_o", mul_res_o, 32'd15);
    finishOp();
    check("MUL hi unchanged", hi_o, 32'd0);
    check("MUL lo unchanged", lo_o, 32'hFFFF_FFFF);

    runOp("MADD -1*3",   MADD, 32'hFFFF_FFFF, 32'd3, 2,  32'd0,         32'hFFFF_FFFC);
    runOp("MSUB -1*3",   MSUB, 32'hFFFF_FFFF, 32'd3, 2,  32'd0,         32'hFFFF_FFFF);

    // Hold DONE for three cycles; MTLO lands on the commit edge and must lose.
    hold_i = 1'b1;
    issue(MADDU, 32'h0001_0000, 32'h0001_0000, doneAt, stallCnt);
    doneCnt = done_o ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        hold_i  = 1'b0;
        mtlo_i  = 1'b1;
        wdata_i = 32'h1234;
      end
      @(negedge clk);
      if (done_o) doneCnt++;
      check("hold hi before commit", hi_o, 32'd0);
    end
    check("hold done_o cycles", doneCnt, 4);
    @(posedge clk);
    #1;
    mtlo_i = 1'b0;
    check("hold single commit hi", hi_o, 32'd1);
    check("hold commit beats mtlo", lo_o, 32'hFFFF_FFFF);

    // Flush in cycle 10 of a divide.
    en_i = 1'b1; op_i = DIVU; a_i = 32'd1000; b_i = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      en_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    check("flush stall_o forced low", stall_o, 1'b0);
    check("flush done_o forced low", done_o, 1'b0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("after flush stall_o", stall_o, 1'b0);
    sawDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) sawDone++;
    end
    check("no done after flush", sawDone, 0);
    check("flush hi unchanged", hi_o, 32'd1);
    check("flush lo unchanged", lo_o, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;

    runOp("MULTU max*max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);

    // Reset pulse in cycle 5 of a divide.
    en_i = 1'b1; op_i = DIV; a_i = 32'd77; b_i = 32'd5;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      en_i = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("after rst stall_o", stall_o, 1'b0);
    check("after rst hi_o", hi_o, 32'h0);
    check("after rst lo_o", lo_o, 32'h0);
    sawDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) sawDone++;
    end
    check("no done after rst", sawDone, 0);
    @(posedge clk);
    #1;

    runOp("MULT min*min", MULT, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
